// File: rtl/soc_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and the tohost pass value.
// Latency: n/a (package only).
// Backpressure: n/a.
package soc_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        RUN,
        HALT
    } loader_state_e;

    localparam int TOHOST_PASS = 1;

endpackage

// File: rtl/soc_cycle_watchdog.sv
// Run-budget counter: counts enabled cycles, saturating at MAX_CYCLES; expired_o flags the final budget cycle.
// Latency: count_o updates one cycle after each enabled cycle; expired_o is combinational from count and enable.
// Backpressure: none.
module soc_cycle_watchdog #(
    parameter int MAX_CYCLES = 1000,
    parameter int CYC_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CYC_W-1:0] count_o,
    output logic             expired_o
);

    localparam logic [CYC_W-1:0] LIMIT = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0] LAST  = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0] STEP  = CYC_W'(1);

    logic [CYC_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + STEP;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High during the cycle whose completion exhausts the budget.
    assign expired_o = en_i && (count_q == LAST);
    assign count_o   = count_q;

endmodule

// File: rtl/soc_program_loader.sv
// Program loader: streams an image into instruction memory, optionally zero-fills the rest, then supervises the core run.
// Latency: memory write one cycle after each accepted word; result flags one cycle after tohost or timeout.
// Backpressure: s_ready_o only in LOAD while words remain, from registered state; the stream may stall freely.
module soc_program_loader
    import soc_loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int MAX_CYCLES = 1000,
    parameter bit FILL_ZERO  = 1'b1,
    parameter int CYC_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   prog_len_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              core_reset_o,
    input  logic              tohost_valid_i,
    input  logic [DATA_W-1:0] tohost_data_i,
    output logic              busy_o,
    output logic              test_pass_o,
    output logic              test_fail_o,
    output logic              timeout_o,
    output logic [DATA_W-2:0] fail_code_o,
    output logic [CYC_W-1:0]  cycle_count_o
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO  = '0;

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d, len_q, len_d;
    logic [ADDR_W:0]   len_start, ptr_inc;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
    logic [DATA_W-2:0] code_q, code_d;
    logic              wd_clear, wd_expired, run;

    assign len_start = (prog_len_i > DEPTH) ? DEPTH : prog_len_i;
    assign ptr_inc   = ptr_q + ONE;
    assign run       = (state_q == RUN);
    assign s_ready_o = (state_q == LOAD) && (ptr_q < len_q);

    soc_cycle_watchdog #(
        .MAX_CYCLES(MAX_CYCLES),
        .CYC_W     (CYC_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (wd_clear),
        .en_i     (run),
        .count_o  (cycle_count_o),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tout_d   = tout_q;
        code_d   = code_q;
        wd_clear = 1'b0;
        unique case (state_q)
            IDLE, HALT: begin
                if (start_i) begin
                    len_d    = len_start;
                    ptr_d    = ZERO;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    tout_d   = 1'b0;
                    code_d   = '0;
                    wd_clear = 1'b1;
                    if (len_start != ZERO) begin
                        state_d = LOAD;
                    end else if (FILL_ZERO) begin
                        state_d = FILL;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            LOAD: begin
                if (s_valid_i && s_ready_o) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[ADDR_W-1:0];
                    wdata_d = s_data_i;
                    ptr_d   = ptr_inc;
                    // Fill follows the image back-to-back; without fill we linger one
                    // cycle so the last write lands before the core leaves reset.
                    if (FILL_ZERO && (ptr_inc == len_q) && (len_q != DEPTH)) begin
                        state_d = FILL;
                    end
                end else if (ptr_q == len_q) begin
                    state_d = RUN;
                end
            end
            FILL: begin
                if (ptr_q != DEPTH) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[ADDR_W-1:0];
                    wdata_d = '0;
                    ptr_d   = ptr_inc;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tohost_valid_i) begin
                    if (tohost_data_i == DATA_W'(TOHOST_PASS)) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                        code_d = tohost_data_i[DATA_W-1:1];
                    end
                    state_d = HALT;
                end else if (wd_expired) begin
                    tout_d  = 1'b1;
                    state_d = HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tout_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tout_q  <= tout_d;
            code_q  <= code_d;
        end
    end

    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_reset_o = !run;
    assign busy_o       = (state_q == LOAD) || (state_q == FILL) || run;
    assign test_pass_o  = pass_q;
    assign test_fail_o  = fail_q;
    assign timeout_o    = tout_q;
    assign fail_code_o  = code_q;

endmodule
